// File: rtl/tpu_dma_responder.sv
// rtl/tpu_dma_responder.sv - TPU DMA responder converting binary words to/from trit-packed data memory
// Optional grant-wait timeout enabled by defining TPU_DMA_TIMEOUT_EN.
module tpu_dma_responder #(
    parameter int          TRIT_WIDTH  = 27,
    parameter logic [31:0] DMEM_BASE   = 32'h0000_0200,
    parameter int          DMEM_DEPTH  = 2048,
    parameter int          TIMEOUT_CYC = 64,
    localparam int         AW          = $clog2(DMEM_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    dma_req,
    input  logic                    dma_wr,
    input  logic [31:0]             dma_addr,
    input  logic [31:0]             dma_wdata,
    output logic [31:0]             dma_rdata,
    output logic                    dma_ack,
    output logic                    dma_err,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [AW-1:0]           mem_addr,
    output logic [2*TRIT_WIDTH-1:0] mem_wdata,
    input  logic [2*TRIT_WIDTH-1:0] mem_rdata,
    input  logic                    mem_gnt
);

    localparam logic [1:0] T_ZERO    = 2'b00;
    localparam logic [1:0] T_POS_ONE = 2'b01;
    localparam logic [1:0] T_NEG_ONE = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_GNT_WAIT, S_RD_WAIT, S_ACK} state_t;

    state_t                  state, state_nxt;
    logic                    wr_q;
    logic [AW-1:0]           addr_q;
    logic [2*TRIT_WIDTH-1:0] wdata_q;
    logic [31:0]             offset;
    logic                    in_range;
    logic                    timeout_hit;
    logic                    unused_upper_trits;

    // Only the 16 trits that fit a 32-bit word are carried; illegal codes read as zero.
    function automatic logic [1:0] legal_trit(input logic [1:0] t);
        return (t == T_POS_ONE || t == T_NEG_ONE) ? t : T_ZERO;
    endfunction

    function automatic logic [2*TRIT_WIDTH-1:0] pack_trits(input logic [31:0] w);
        logic [2*TRIT_WIDTH-1:0] p;
        p = {TRIT_WIDTH{T_ZERO}};
        for (int i = 0; i < 16; i++) p[2*i +: 2] = legal_trit(w[2*i +: 2]);
        return p;
    endfunction

    function automatic logic [31:0] unpack_trits(input logic [31:0] p);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 16; i++) w[2*i +: 2] = legal_trit(p[2*i +: 2]);
        return w;
    endfunction

    assign offset             = dma_addr - DMEM_BASE;
    assign in_range           = (dma_addr >= DMEM_BASE) && (offset < 32'(DMEM_DEPTH));
    assign unused_upper_trits = ^mem_rdata[2*TRIT_WIDTH-1:32];

`ifdef TPU_DMA_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] wait_cnt;

    // Counter is zero whenever not waiting, so every GNT_WAIT entry starts fresh.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      wait_cnt <= '0;
        else if (state != S_GNT_WAIT) wait_cnt <= '0;
        else                          wait_cnt <= wait_cnt + CW'(1);
    end

    assign timeout_hit = (wait_cnt == CW'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (dma_req) state_nxt = in_range ? S_GNT_WAIT : S_ACK;
            S_GNT_WAIT: begin
                if (mem_gnt)          state_nxt = wr_q ? S_ACK : S_RD_WAIT;
                else if (timeout_hit) state_nxt = S_ACK;
            end
            S_RD_WAIT:  state_nxt = S_ACK;
            S_ACK:      state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req = (state == S_GNT_WAIT);
        mem_we  = (state == S_GNT_WAIT) && wr_q;
        dma_ack = (state == S_ACK);
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            dma_err   <= 1'b0;
            dma_rdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (dma_req) begin
                        wr_q    <= dma_wr;
                        addr_q  <= offset[AW-1:0];
                        wdata_q <= pack_trits(dma_wdata);
                        dma_err <= !in_range;
                        if (!in_range) dma_rdata <= '0;
                    end
                end
                S_GNT_WAIT: begin
                    if (!mem_gnt && timeout_hit) begin
                        dma_err   <= 1'b1;
                        dma_rdata <= '0;
                    end
                end
                S_RD_WAIT: dma_rdata <= unpack_trits(mem_rdata[31:0]);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tpu_dma_responder.sv
// tb/tb_tpu_dma_responder.sv - directed self-checking bench for tpu_dma_responder
module tb_tpu_dma_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dma_req = 1'b0;
    logic        dma_wr = 1'b0;
    logic [31:0] dma_addr = '0;
    logic [31:0] dma_wdata = '0;
    logic [31:0] dma_rdata;
    logic        dma_ack;
    logic        dma_err;
    logic        mem_req;
    logic        mem_we;
    logic [10:0] mem_addr;
    logic [53:0] mem_wdata;
    logic [53:0] mem_rdata;
    logic        mem_gnt;
    logic        gnt_en = 1'b0;

    logic        pl_en = 1'b0;
    logic [10:0] pl_addr = '0;
    logic [53:0] pl_data = '0;
    logic        mem_clr = 1'b0;
    logic [53:0] mem [0:2047];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;
    assign mem_gnt = gnt_en;

    tpu_dma_responder #(.TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst(rst),
        .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack), .dma_err(dma_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_gnt(mem_gnt)
    );

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 2048; i++) mem[i] <= '0;
        end else if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (mem_req && mem_gnt) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic preload(input logic [10:0] a, input logic [53:0] d);
        @(negedge clk);
        pl_addr = a; pl_data = d; pl_en = 1'b1;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input int max_cyc, output int lat, output logic err,
                          output logic [31:0] rd, output logic saw_mreq);
        lat = 0; err = 1'b0; rd = '0; saw_mreq = 1'b0;
        @(negedge clk);
        dma_req = 1'b1; dma_wr = wr; dma_addr = addr; dma_wdata = wd;
        for (int n = 1; n <= max_cyc; n++) begin
            @(posedge clk); #1;
            if (mem_req) saw_mreq = 1'b1;
            if (dma_ack) begin
                lat = n; err = dma_err; rd = dma_rdata;
                break;
            end
        end
        dma_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic ok;
        #1;
        vectors++;
        if ({dma_ack, dma_err, dma_rdata, mem_req, mem_we, mem_addr, mem_wdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got ack=%b err=%b rdata=%h req=%b we=%b addr=%h wdata=%h, want all 0",
                     dma_ack, dma_err, dma_rdata, mem_req, mem_we, mem_addr, mem_wdata);
        end
        @(negedge clk); mem_clr = 1'b1;
        @(negedge clk); mem_clr = 1'b0; rst = 1'b0;
        gnt_en = 1'b0;
        @(negedge clk);
        dma_req = 1'b1; dma_wr = 1'b1; dma_addr = 32'h0210; dma_wdata = 32'h0000_0005;
        @(posedge clk); #1;
        vectors++;
        if (mem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_pre_gnt_wait: mem_req=%b, want 1", mem_req);
        end
        @(negedge clk); rst = 1'b1; #1;
        vectors++;
        if (mem_req !== 1'b0 || dma_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_txn: mem_req=%b dma_ack=%b, want 0 0", mem_req, dma_ack);
        end
        dma_req = 1'b0;
        @(negedge clk); rst = 1'b0; gnt_en = 1'b1;
        ok = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); #1;
            if (dma_ack || mem_req) ok = 1'b0;
        end
        vectors++;
        if (ok !== 1'b1 || mem[16] !== 54'h0) begin
            miscompares++;
            $display("FAIL reset_no_write: quiet=%b mem[16]=%h, want 1 and 0", ok, mem[16]);
        end
    endtask

    task automatic test_write();
        int lat; logic err; logic [31:0] rd; logic sm;
        gnt_en = 1'b1;
        do_req(1'b1, 32'h0205, 32'h0000_0006, 10, lat, err, rd, sm);
        vectors++;
        if (lat !== 2 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL write_latency: lat=%0d err=%b, want 2 0", lat, err);
        end
        vectors++;
        if (mem[5] !== 54'h6) begin
            miscompares++;
            $display("FAIL write_packing: mem[5]=%h, want %h", mem[5], 54'h6);
        end
        do_req(1'b1, 32'h0206, 32'hFFFF_FFFF, 10, lat, err, rd, sm);
        vectors++;
        if (mem[6] !== 54'h0) begin
            miscompares++;
            $display("FAIL write_invalid_codes: mem[6]=%h, want 0", mem[6]);
        end
        do_req(1'b1, 32'h0207, 32'hC000_0009, 10, lat, err, rd, sm);
        vectors++;
        if (mem[7] !== 54'h9) begin
            miscompares++;
            $display("FAIL write_mixed_codes: mem[7]=%h, want 9", mem[7]);
        end
        do_req(1'b1, 32'h09FF, 32'h0000_0041, 10, lat, err, rd, sm);
        vectors++;
        if (mem[2047] !== 54'h41 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL write_top_word: mem[2047]=%h err=%b, want 41 0", mem[2047], err);
        end
    endtask

    task automatic test_read();
        int lat; logic err; logic [31:0] rd; logic sm;
        gnt_en = 1'b1;
        do_req(1'b0, 32'h0205, 32'h0, 10, lat, err, rd, sm);
        vectors++;
        if (lat !== 3 || err !== 1'b0 || rd !== 32'h0000_0006) begin
            miscompares++;
            $display("FAIL read_back: lat=%0d err=%b rdata=%h, want 3 0 00000006", lat, err, rd);
        end
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (dma_rdata !== 32'h0000_0006) begin
            miscompares++;
            $display("FAIL read_hold: rdata=%h, want 00000006", dma_rdata);
        end
        do_req(1'b0, 32'h09FF, 32'h0, 10, lat, err, rd, sm);
        vectors++;
        if (rd !== 32'h0000_0041 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL read_top_word: rdata=%h err=%b, want 00000041 0", rd, err);
        end
    endtask

    task automatic test_range();
        int lat; logic err; logic [31:0] rd; logic sm;
        logic [31:0] addrs [2];
        addrs[0] = 32'h0A00; addrs[1] = 32'h01FF;
        gnt_en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            do_req(1'b0, addrs[k], 32'h0, 10, lat, err, rd, sm);
            vectors++;
            if (lat !== 1 || err !== 1'b1 || rd !== 32'h0 || sm !== 1'b0) begin
                miscompares++;
                $display("FAIL range_err_%h: lat=%0d err=%b rdata=%h mem_req_seen=%b, want 1 1 0 0",
                         addrs[k], lat, err, rd, sm);
            end
        end
    endtask

    task automatic test_gnt_wait();
        logic ok; int lat;
        gnt_en = 1'b0;
        @(negedge clk);
        dma_req = 1'b1; dma_wr = 1'b0; dma_addr = 32'h0205;
        ok = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            if (!mem_req || dma_ack) ok = 1'b0;
        end
        vectors++;
        if (ok !== 1'b1) begin
            miscompares++;
            $display("FAIL gnt_wait_hold: mem_req held=%b, want 1", ok);
        end
        @(negedge clk); gnt_en = 1'b1;
        lat = 0;
        for (int n = 1; n <= 6; n++) begin
            @(posedge clk); #1;
            if (dma_ack) begin lat = n; break; end
        end
        vectors++;
        if (lat !== 2 || dma_rdata !== 32'h0000_0006) begin
            miscompares++;
            $display("FAIL gnt_wait_ack: lat=%0d rdata=%h, want 2 00000006", lat, dma_rdata);
        end
        dma_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int lat;
        preload(11'd100, {22'h155555, 32'h9A5A_6151});
        gnt_en = 1'b1;
        @(negedge clk);
        dma_req = 1'b1; dma_wr = 1'b0; dma_addr = 32'h0205;
        lat = 0;
        for (int n = 1; n <= 6; n++) begin
            @(posedge clk); #1;
            if (dma_ack) begin lat = n; break; end
        end
        dma_addr = 32'h0264;
        @(posedge clk); #1;
        vectors++;
        if (lat !== 3 || mem_req !== 1'b0 || dma_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_idle_gap: first_lat=%0d mem_req=%b ack=%b, want 3 0 0", lat, mem_req, dma_ack);
        end
        @(posedge clk); #1;
        vectors++;
        if (mem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_second_start: mem_req=%b, want 1", mem_req);
        end
        lat = 0;
        for (int n = 1; n <= 6; n++) begin
            @(posedge clk); #1;
            if (dma_ack) begin lat = n; break; end
        end
        vectors++;
        if (lat !== 2 || dma_rdata !== 32'h9A5A_6151) begin
            miscompares++;
            $display("FAIL b2b_second_read: lat=%0d rdata=%h, want 2 9a5a6151", lat, dma_rdata);
        end
        dma_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        int lat; logic err; logic [31:0] rd; logic sm;
        gnt_en = 1'b0;
        do_req(1'b1, 32'h020A, 32'h0000_0005, 100, lat, err, rd, sm);
`ifdef TPU_DMA_TIMEOUT_EN
        vectors++;
        if (lat !== 9 || err !== 1'b1 || rd !== 32'h0) begin
            miscompares++;
            $display("FAIL timeout_ack: lat=%0d err=%b rdata=%h, want 9 1 0", lat, err, rd);
        end
`else
        vectors++;
        if (lat !== 0) begin
            miscompares++;
            $display("FAIL no_timeout: ack after %0d cycles, want no ack in 100", lat);
        end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
`endif
        gnt_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (mem[10] !== 54'h0) begin
            miscompares++;
            $display("FAIL timeout_no_write: mem[10]=%h, want 0", mem[10]);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_range();
        test_gnt_wait();
        test_back_to_back();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
